// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states, iteration counts and helpers.
package alu_pkg;

  localparam int unsigned DIV_ITER_64 = 64;
  localparam int unsigned DIV_ITER_32 = 32;
  localparam int unsigned DIV_CNT_W   = 7;
  localparam int unsigned DIV_DATA_W  = 64;
  localparam int unsigned DIV_HALF_W  = DIV_DATA_W / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Zero the upper half of a word when running in 32-bit ALU mode.
  function automatic logic [DIV_DATA_W-1:0] mask_alu32(input logic [DIV_DATA_W-1:0] x,
                                                       input logic alu32);
    return alu32 ? {{DIV_HALF_W{1'b0}}, x[DIV_HALF_W-1:0]} : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the dividend MSB, subtract if it fits.
module div_step #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next_c,
  output logic             q_bit_c
);

  logic [WIDTH:0] t;

  // Compare the 65-bit partial remainder against the divisor; the difference always fits in WIDTH bits.
  always_comb begin
    t        = {r, q_msb};
    q_bit_c  = (t >= {1'b0, divisor});
    r_next_c = q_bit_c ? (t[WIDTH-1:0] - divisor) : t[WIDTH-1:0];
  end

endmodule

// File: rtl/division_64bit.sv
// Iterative unsigned divider for eBPF DIV/MOD in 64-bit and 32-bit ALU modes.
module division_64bit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_mod,
  input  logic             is_alu32,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] c
);

  localparam int unsigned HALF_W = WIDTH / 2;

  div_state_t           state_q, state_d;
  logic [WIDTH-1:0]     r_q, r_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic                 mod_q, mod_d;
  logic                 alu32_q, alu32_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     c_q, c_d;

  logic                 accept_c;
  logic [WIDTH-1:0]     a_m_c;
  logic [WIDTH-1:0]     b_m_c;
  logic [WIDTH-1:0]     r_step_c;
  logic                 q_bit_c;
  logic [WIDTH-1:0]     q_step_c;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r        (r_q),
    .q_msb    (q_q[WIDTH-1]),
    .divisor  (dvs_q),
    .r_next_c (r_step_c),
    .q_bit_c  (q_bit_c)
  );

  // Accept decode, operand masking and the shifted quotient for this step.
  always_comb begin
    accept_c = start && ready_q;
    a_m_c    = mask_alu32(a, is_alu32);
    b_m_c    = mask_alu32(b, is_alu32);
    q_step_c = {q_q[WIDTH-2:0], q_bit_c};
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      mod_q   <= 1'b0;
      alu32_q <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      mod_q   <= mod_d;
      alu32_q <= alu32_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      c_q     <= c_d;
    end
  end

  // Next-state logic: zero divisor short-circuits straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept_c) begin
          state_d = (b_m_c == '0) ? DONE : CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (cnt_q == DIV_CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output updates; results are registered on entry to DONE.
  always_comb begin
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    mod_d   = mod_q;
    alu32_d = alu32_q;
    c_d     = c_q;
    valid_d = 1'b0;
    ready_d = (state_d != CALC);
    case (state_q)
      IDLE, DONE: begin
        if (accept_c) begin
          mod_d   = is_mod;
          alu32_d = is_alu32;
          dvs_d   = b_m_c;
          r_d     = '0;
          q_d     = is_alu32 ? (a_m_c << HALF_W) : a_m_c;
          cnt_d   = is_alu32 ? DIV_CNT_W'(DIV_ITER_32) : DIV_CNT_W'(DIV_ITER_64);
          if (b_m_c == '0) begin
            valid_d = 1'b1;
            c_d     = is_mod ? a_m_c : '0;
          end
        end
      end
      CALC: begin
        r_d   = r_step_c;
        q_d   = q_step_c;
        cnt_d = cnt_q - DIV_CNT_W'(1);
        if (cnt_q == DIV_CNT_W'(1)) begin
          valid_d = 1'b1;
          c_d     = mask_alu32(mod_q ? r_step_c : q_step_c, alu32_q);
        end
      end
      default: ;
    endcase
  end

  assign ready = ready_q;
  assign valid = valid_q;
  assign c     = c_q;

endmodule

// File: tb/tb_division_64bit.sv
// Directed bench for division_64bit: latency, results, handshake and reset behaviour.
module tb_division_64bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_mod;
  logic        is_alu32;
  logic [63:0] a;
  logic [63:0] b;
  logic        ready;
  logic        valid;
  logic [63:0] c;

  int checks;
  int failures;

  division_64bit #(.WIDTH(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .is_mod   (is_mod),
    .is_alu32 (is_alu32),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .valid    (valid),
    .c        (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a clock edge with ready high; returns 1 unit after the accept edge.
  task automatic accept_op(input logic m, input logic w32, input logic [63:0] av, input logic [63:0] bv);
    start    = 1'b1;
    is_mod   = m;
    is_alu32 = w32;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom();
    b     = {$urandom(), $urandom()};
  endtask

  // n0 is the number of edges already elapsed since the accept edge.
  task automatic wait_valid(input string tag, input int n0, input int exp_lat, input logic [63:0] exp_c);
    int n;
    n = n0;
    while (!valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_valid"}, 64'(valid), 64'(1));
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_c"}, c, exp_c);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [63:0] ra, rb, ma, mb, ec;
    logic        rm, rw;
    int          el, pulses;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    is_mod   = 1'b0;
    is_alu32 = 1'b0;
    a        = '0;
    b        = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'(1));
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_c", c, 64'd0);
    rst = 1'b0;
    idle_cycles(1);

    // 64-bit basic div/mod
    accept_op(1'b0, 1'b0, 64'd100, 64'd7);
    check("div64_busy", 64'(ready), 64'(0));
    wait_valid("div64", 1, 65, 64'd14);
    check("div64_ready_done", 64'(ready), 64'(1));
    idle_cycles(1);
    check("div64_pulse", 64'(valid), 64'(0));
    check("div64_hold", c, 64'd14);
    accept_op(1'b1, 1'b0, 64'd100, 64'd7);
    wait_valid("mod64", 1, 65, 64'd2);
    idle_cycles(1);

    // Maximum operands
    accept_op(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    wait_valid("max_div1", 1, 65, 64'hFFFF_FFFF_FFFF_FFFF);
    idle_cycles(1);
    accept_op(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_valid("max_divmax", 1, 65, 64'd1);
    idle_cycles(1);
    accept_op(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_valid("max_modmax", 1, 65, 64'd0);
    idle_cycles(1);

    // 32-bit mode ignores upper operand bits
    accept_op(1'b0, 1'b1, 64'hDEAD_BEEF_0000_0064, 64'hFFFF_FFFF_0000_000A);
    wait_valid("div32", 1, 33, 64'd10);
    idle_cycles(1);
    accept_op(1'b1, 1'b1, 64'hDEAD_BEEF_0000_0064, 64'hFFFF_FFFF_0000_000A);
    wait_valid("mod32", 1, 33, 64'd0);
    idle_cycles(1);

    // Divide by zero
    accept_op(1'b0, 1'b0, 64'd55, 64'd0);
    wait_valid("dz_div", 1, 1, 64'd0);
    idle_cycles(1);
    accept_op(1'b1, 1'b0, 64'd55, 64'd0);
    wait_valid("dz_mod", 1, 1, 64'd55);
    idle_cycles(1);
    accept_op(1'b1, 1'b1, 64'h1_0000_0005, 64'hABCD_0000_0000_0000);
    wait_valid("dz_mod32", 1, 1, 64'd5);
    idle_cycles(1);

    // Back-to-back: start during DONE is accepted
    accept_op(1'b0, 1'b0, 64'd100, 64'd7);
    wait_valid("b2b_first", 1, 65, 64'd14);
    accept_op(1'b0, 1'b0, 64'd9, 64'd3);
    wait_valid("b2b_second", 1, 65, 64'd3);
    idle_cycles(1);

    // Start pulses during CALC are ignored and not queued
    accept_op(1'b0, 1'b0, 64'd1000, 64'd10);
    idle_cycles(9);
    start = 1'b1;
    a     = 64'd1;
    b     = 64'd1;
    idle_cycles(1);
    start = 1'b0;
    check("calc_start_c", c, 64'd3);
    check("calc_start_ready", 64'(ready), 64'(0));
    wait_valid("calc_start", 11, 65, 64'd100);
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      if (valid) pulses++;
    end
    check("no_queued_op", 64'(pulses), 64'd0);

    // Reset in the middle of CALC
    accept_op(1'b0, 1'b0, 64'd100, 64'd7);
    idle_cycles(19);
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    check("midrst_ready", 64'(ready), 64'(1));
    check("midrst_valid", 64'(valid), 64'(0));
    check("midrst_c", c, 64'd0);
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      if (valid) pulses++;
    end
    check("midrst_no_valid", 64'(pulses), 64'd0);

    // Random operands against the language's divide/modulo operators
    for (int i = 0; i < 60; i++) begin
      rw = 1'(i % 2);
      rm = 1'($urandom_range(0, 1));
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      if (i % 15 == 7) rb = 64'd0;
      ma = rw ? {32'd0, ra[31:0]} : ra;
      mb = rw ? {32'd0, rb[31:0]} : rb;
      if (mb == 64'd0) begin
        ec = rm ? ma : 64'd0;
        el = 1;
      end else begin
        ec = rm ? (ma % mb) : (ma / mb);
        el = rw ? 33 : 65;
      end
      accept_op(rm, rw, ra, rb);
      wait_valid($sformatf("rand%0d", i), 1, el, ec);
      idle_cycles(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
